// File: rtl/video_timing_meter.sv
// Video timing meter: live position counters, per-frame published geometry and
// a lock state machine that asserts only after LOCK_FRAMES identical clean frames.
module video_timing_meter #(
  parameter int CW          = 16,
  parameter int PW          = 32,
  parameter int FW          = 16,
  parameter int LOCK_FRAMES = 4
) (
  input  logic          odck,
  input  logic          rst,
  input  logic          scdt,
  input  logic          vsync_in,
  input  logic          hsync_in,
  input  logic          de_in,
  output logic [CW-1:0] now_x,
  output logic [CW-1:0] now_y,
  output logic [PW-1:0] now_pxl,
  output logic [CW-1:0] active_x,
  output logic [CW-1:0] active_y,
  output logic [PW-1:0] active_pxl,
  output logic [CW-1:0] total_x,
  output logic [CW-1:0] total_y,
  output logic [FW-1:0] frame_cnt,
  output logic          meas_valid,
  output logic          locked,
  output logic          ovf
);

  localparam int MW = $clog2(LOCK_FRAMES) + 1;
  localparam logic [MW-1:0] LF = MW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEEK    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  function automatic logic [CW-1:0] inc_c(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  function automatic logic [PW-1:0] inc_p(input logic [PW-1:0] v);
    return (v == {PW{1'b1}}) ? v : v + PW'(1);
  endfunction

  logic          r_de_q, r_vs_q, r_hs_q, r_de_d, r_vs_d, r_hs_d;
  logic [CW-1:0] r_now_x, r_now_y, r_hcnt, r_he_cnt;
  logic [PW-1:0] r_now_pxl;
  logic [CW-1:0] r_lref, r_tref;
  logic          r_unstable, r_sat;
  logic [CW-1:0] r_active_x, r_active_y, r_total_x, r_total_y;
  logic [PW-1:0] r_active_pxl;
  logic [FW-1:0] r_frame_cnt;
  logic          r_meas_valid, r_locked, r_ovf;
  logic [MW-1:0] r_match_cnt;
  state_t        r_state;

  logic          w_clear, w_fe, w_le, w_he;
  logic          w_x_sat, w_p_sat, w_y_sat, w_h_sat, w_e_sat;
  logic          w_line_bad, w_tot_bad;
  logic [CW-1:0] w_fin_ax, w_fin_ay;
  logic          w_fin_unstable, w_fin_sat, w_clean, w_same;
  logic [MW-1:0] w_match_nx;

  assign w_clear = rst | ~scdt;
  assign w_fe    = r_vs_d & ~r_vs_q;
  assign w_le    = r_de_d & ~r_de_q;
  assign w_he    = r_hs_q & ~r_hs_d;

  assign w_x_sat = r_de_q & (r_now_x == {CW{1'b1}});
  assign w_p_sat = r_de_q & (r_now_pxl == {PW{1'b1}});
  assign w_y_sat = w_le & (r_now_y == {CW{1'b1}});
  assign w_h_sat = ~w_he & (r_hcnt == {CW{1'b1}});
  assign w_e_sat = w_he & (r_he_cnt == {CW{1'b1}});

  // A zero reference means "not yet captured": a DE run is always at least one cycle.
  assign w_line_bad = w_le & (r_lref != '0) & (r_now_x != r_lref);
  assign w_tot_bad  = w_he & (r_he_cnt >= CW'(2)) & (r_hcnt != r_tref);

  // A line ending on the frame-end cycle still belongs to the ending frame.
  assign w_fin_ax       = (r_lref != '0) ? r_lref : (w_le ? r_now_x : '0);
  assign w_fin_ay       = w_le ? inc_c(r_now_y) : r_now_y;
  assign w_fin_unstable = r_unstable | w_line_bad;
  assign w_fin_sat      = r_sat | w_y_sat;
  assign w_clean        = ~w_fin_unstable & ~w_fin_sat;
  assign w_same         = (w_fin_ax == r_active_x) && (w_fin_ay == r_active_y) &&
                          (r_tref == r_total_x) && (r_he_cnt == r_total_y);

  // Next match count for the frame being published.
  always_comb begin
    w_match_nx = '0;
    if (w_clean) begin
      if ((r_match_cnt != '0) && w_same) begin
        if (r_match_cnt >= LF) begin
          w_match_nx = LF;
        end else begin
          w_match_nx = r_match_cnt + MW'(1);
        end
      end else begin
        w_match_nx = MW'(1);
      end
    end else begin
      w_match_nx = '0;
    end
  end

  // Input registers and live position / interval counters.
  always_ff @(posedge odck) begin
    if (w_clear) begin
      r_de_q    <= 1'b0;
      r_vs_q    <= 1'b0;
      r_hs_q    <= 1'b0;
      r_de_d    <= 1'b0;
      r_vs_d    <= 1'b0;
      r_hs_d    <= 1'b0;
      r_now_x   <= '0;
      r_now_y   <= '0;
      r_now_pxl <= '0;
      r_hcnt    <= '0;
      r_he_cnt  <= '0;
    end else begin
      r_de_q  <= de_in;
      r_vs_q  <= vsync_in;
      r_hs_q  <= hsync_in;
      r_de_d  <= r_de_q;
      r_vs_d  <= r_vs_q;
      r_hs_d  <= r_hs_q;
      r_now_x <= r_de_q ? inc_c(r_now_x) : '0;
      r_hcnt  <= w_he ? CW'(1) : inc_c(r_hcnt);
      if (w_fe) begin
        r_now_y   <= '0;
        r_now_pxl <= r_de_q ? PW'(1) : '0;
        r_he_cnt  <= w_he ? CW'(1) : '0;
      end else begin
        r_now_y   <= w_le ? inc_c(r_now_y) : r_now_y;
        r_now_pxl <= r_de_q ? inc_p(r_now_pxl) : r_now_pxl;
        r_he_cnt  <= w_he ? inc_c(r_he_cnt) : r_he_cnt;
      end
    end
  end

  // Per-frame reference lengths and stability / saturation flags.
  always_ff @(posedge odck) begin
    if (w_clear) begin
      r_lref     <= '0;
      r_tref     <= '0;
      r_unstable <= 1'b0;
      r_sat      <= 1'b0;
    end else if (w_fe) begin
      r_lref     <= '0;
      r_tref     <= '0;
      r_unstable <= 1'b0;
      r_sat      <= w_x_sat | w_h_sat;
    end else begin
      if (w_le && (r_lref == '0)) begin
        r_lref <= r_now_x;
      end
      if (w_he && (r_he_cnt == CW'(1))) begin
        r_tref <= r_hcnt;
      end
      r_unstable <= r_unstable | w_line_bad | w_tot_bad;
      r_sat      <= r_sat | w_x_sat | w_p_sat | w_y_sat | w_h_sat | w_e_sat;
    end
  end

  // Lock state machine with registered published outputs.
  always_ff @(posedge odck) begin
    if (w_clear) begin
      r_state      <= ST_SEEK;
      r_match_cnt  <= '0;
      r_active_x   <= '0;
      r_active_y   <= '0;
      r_active_pxl <= '0;
      r_total_x    <= '0;
      r_total_y    <= '0;
      r_frame_cnt  <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      case (r_state)
        ST_SEEK: begin
          if (w_fe) begin
            r_state <= ST_ACQUIRE;
          end
        end
        ST_ACQUIRE, ST_LOCKED: begin
          if (w_fe) begin
            r_active_x   <= w_fin_ax;
            r_active_y   <= w_fin_ay;
            r_active_pxl <= r_now_pxl;
            r_total_x    <= r_tref;
            r_total_y    <= r_he_cnt;
            r_frame_cnt  <= r_frame_cnt + FW'(1);
            r_meas_valid <= 1'b1;
            r_ovf        <= w_fin_sat;
            r_match_cnt  <= w_match_nx;
            if (r_state == ST_LOCKED) begin
              if (!(w_clean && w_same)) begin
                r_locked <= 1'b0;
                r_state  <= ST_ACQUIRE;
              end
            end else if (w_match_nx == LF) begin
              r_locked <= 1'b1;
              r_state  <= ST_LOCKED;
            end
          end
        end
        default: begin
          r_state  <= ST_SEEK;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign now_x      = r_now_x;
  assign now_y      = r_now_y;
  assign now_pxl    = r_now_pxl;
  assign active_x   = r_active_x;
  assign active_y   = r_active_y;
  assign active_pxl = r_active_pxl;
  assign total_x    = r_total_x;
  assign total_y    = r_total_y;
  assign frame_cnt  = r_frame_cnt;
  assign meas_valid = r_meas_valid;
  assign locked     = r_locked;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_video_timing_meter.sv
// Scoreboard bench for video_timing_meter: a default-width instance and a CW=4
// instance share one directed video stream; monitors check every publish.
module tb_video_timing_meter;

  localparam int EV_NONE = 0;
  localparam int EV_RST  = 1;
  localparam int EV_SCDT = 2;

  logic odck = 1'b0;
  logic rst, scdt, vsync_in, hsync_in, de_in;

  logic [15:0] b_now_x, b_now_y, b_active_x, b_active_y, b_total_x, b_total_y, b_frame_cnt;
  logic [31:0] b_now_pxl, b_active_pxl;
  logic        b_meas_valid, b_locked, b_ovf;

  logic [3:0]  s_now_x, s_now_y, s_active_x, s_active_y, s_total_x, s_total_y;
  logic [15:0] s_frame_cnt;
  logic [31:0] s_now_pxl, s_active_pxl;
  logic        s_meas_valid, s_locked, s_ovf;

  typedef struct {
    int ax; int ay; int ap; int tx; int ty; int fc; int lk; int ov;
  } exp_t;

  exp_t exp_q_b[$];
  exp_t exp_q_s[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n = 0;
  int   fall_cyc = 0;
  logic prev_vs = 1'b0;
  logic small_en = 1'b0;

  video_timing_meter u_big (
    .odck(odck), .rst(rst), .scdt(scdt), .vsync_in(vsync_in), .hsync_in(hsync_in), .de_in(de_in),
    .now_x(b_now_x), .now_y(b_now_y), .now_pxl(b_now_pxl),
    .active_x(b_active_x), .active_y(b_active_y), .active_pxl(b_active_pxl),
    .total_x(b_total_x), .total_y(b_total_y), .frame_cnt(b_frame_cnt),
    .meas_valid(b_meas_valid), .locked(b_locked), .ovf(b_ovf)
  );

  video_timing_meter #(.CW(4)) u_small (
    .odck(odck), .rst(rst), .scdt(scdt), .vsync_in(vsync_in), .hsync_in(hsync_in), .de_in(de_in),
    .now_x(s_now_x), .now_y(s_now_y), .now_pxl(s_now_pxl),
    .active_x(s_active_x), .active_y(s_active_y), .active_pxl(s_active_pxl),
    .total_x(s_total_x), .total_y(s_total_y), .frame_cnt(s_frame_cnt),
    .meas_valid(s_meas_valid), .locked(s_locked), .ovf(s_ovf)
  );

  always #5 odck = ~odck;

  always @(posedge odck) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic any_b();
    return |{b_now_x, b_now_y, b_now_pxl, b_active_x, b_active_y, b_active_pxl,
             b_total_x, b_total_y, b_frame_cnt, b_meas_valid, b_locked, b_ovf};
  endfunction

  function automatic logic any_s();
    return |{s_now_x, s_now_y, s_now_pxl, s_active_x, s_active_y, s_active_pxl,
             s_total_x, s_total_y, s_frame_cnt, s_meas_valid, s_locked, s_ovf};
  endfunction

  task automatic push_b(input int ax, ay, ap, tx, ty, fc, lk, ov);
    exp_t e;
    e = '{ax, ay, ap, tx, ty, fc, lk, ov};
    exp_q_b.push_back(e);
  endtask

  task automatic push_s(input int ax, ay, ap, tx, ty, fc, lk, ov);
    exp_t e;
    e = '{ax, ay, ap, tx, ty, fc, lk, ov};
    exp_q_s.push_back(e);
  endtask

  task automatic drive(input logic hs, input logic vs, input logic de);
    hsync_in = hs;
    vsync_in = vs;
    de_in    = de;
    if (!vs && prev_vs) fall_cyc = cyc_n;
    prev_vs = vs;
  endtask

  // 6-line frame: lines 0-3 carry DE from cycle 2, line 5 carries vsync.
  task automatic send_frame(input int w, input int htot, input int shortl, input int ev);
    for (int l = 0; l < 6; l++) begin
      for (int c = 0; c < htot; c++) begin
        int wl;
        @(negedge odck);
        if (l == 0 && c == w + 3) begin
          chk("b_now_x_live", b_now_x, w);
          chk("s_now_x_live", s_now_x, (w > 15) ? 15 : w);
        end
        if (l == 1 && ev != EV_NONE) begin
          if (c >= 5 && c <= ((ev == EV_RST) ? 7 : 6)) begin
            chk("b_outputs_cleared", any_b(), 0);
            chk("s_outputs_cleared", any_s(), 0);
          end
          rst  = (ev == EV_RST) && (c >= 4) && (c <= 6);
          scdt = !((ev == EV_SCDT) && (c >= 4) && (c <= 5));
        end
        wl = (l == shortl) ? 7 : w;
        drive(c == 0, l == 5, (l < 4) && (c >= 2) && (c < 2 + wl));
      end
    end
  endtask

  task automatic send_tail();
    for (int c = 0; c < 30; c++) begin
      @(negedge odck);
      drive(c == 0, 1'b0, 1'b0);
    end
  endtask

  // Monitor for the default-width instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge odck);
      #1;
      if (b_meas_valid) begin
        if (exp_q_b.size() == 0) begin
          chk("b_unexpected_meas_valid", 1, 0);
        end else begin
          e = exp_q_b.pop_front();
          chk("b_active_x", b_active_x, e.ax);
          chk("b_active_y", b_active_y, e.ay);
          chk("b_active_pxl", b_active_pxl, e.ap);
          chk("b_total_x", b_total_x, e.tx);
          chk("b_total_y", b_total_y, e.ty);
          chk("b_frame_cnt", b_frame_cnt, e.fc);
          chk("b_locked", b_locked, e.lk);
          chk("b_ovf", b_ovf, e.ov);
          chk("b_latency", cyc_n - fall_cyc, 2);
        end
      end
    end
  end

  // Monitor for the CW=4 instance, active only for the saturation phase.
  initial begin
    exp_t e;
    forever begin
      @(posedge odck);
      #1;
      if (small_en && s_meas_valid) begin
        if (exp_q_s.size() == 0) begin
          chk("s_unexpected_meas_valid", 1, 0);
        end else begin
          e = exp_q_s.pop_front();
          chk("s_active_x", s_active_x, e.ax);
          chk("s_active_y", s_active_y, e.ay);
          chk("s_active_pxl", s_active_pxl, e.ap);
          chk("s_total_x", s_total_x, e.tx);
          chk("s_total_y", s_total_y, e.ty);
          chk("s_frame_cnt", s_frame_cnt, e.fc);
          chk("s_locked", s_locked, e.lk);
          chk("s_ovf", s_ovf, e.ov);
          chk("s_latency", cyc_n - fall_cyc, 2);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; scdt = 1'b1; vsync_in = 1'b0; hsync_in = 1'b0; de_in = 1'b0;
    repeat (4) @(negedge odck);
    chk("b_reset_state", any_b(), 0);
    chk("s_reset_state", any_s(), 0);
    rst = 1'b0;
    repeat (5) @(negedge odck);

    // Reset during active video; the following frame end is discarded.
    send_frame(8, 12, -1, EV_RST);

    // Steady 8x4 / 12x6 video locks on the 4th publish.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8, 12, -1, EV_NONE);
      push_b(8, 4, 32, 12, 6, i, (i >= 4) ? 1 : 0, 0);
    end

    // One 9-wide frame drops lock; relock on the 4th publish after it.
    send_frame(9, 12, -1, EV_NONE);
    push_b(9, 4, 36, 12, 6, 6, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      send_frame(8, 12, -1, EV_NONE);
      push_b(8, 4, 32, 12, 6, 6 + i, (i == 4) ? 1 : 0, 0);
    end

    // A single 7-pixel line makes the frame unstable.
    send_frame(8, 12, 2, EV_NONE);
    push_b(8, 4, 31, 12, 6, 11, 0, 0);

    // Signal-detect loss mid-frame: cleared, next frame end discarded, relock.
    send_frame(8, 12, -1, EV_SCDT);
    for (int i = 1; i <= 4; i++) begin
      send_frame(8, 12, -1, EV_NONE);
      push_b(8, 4, 32, 12, 6, i, (i == 4) ? 1 : 0, 0);
    end

    // 20-pixel lines: the CW=4 instance saturates, the wide one measures normally.
    send_frame(20, 24, -1, EV_RST);
    small_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      send_frame(20, 24, -1, EV_NONE);
      push_b(20, 4, 80, 24, 6, i, 0, 0);
      push_s(15, 4, 80, 15, 6, i, 0, 1);
    end
    send_tail();
    repeat (10) @(negedge odck);

    chk("b_pending_publishes", exp_q_b.size(), 0);
    chk("s_pending_publishes", exp_q_s.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
